dsi_lane_distributor: RTL

- Parametrised successor to the DSI lane manager. It accepts a byte stream of fully formed DSI packets (headers, payload and CRC already built upstream) and stripes the bytes round-robin across 1..NUM_LANES active PPI data lanes.
- It sequences the per-lane HS enables through prepare, data and trail phases, supports PPI backpressure, and handles a final beat that covers only some of the lanes.
- It sits between the packet builder and the D-PHY PPI.

---
 rtl/dsi_lane_pkg.sv | 15 +
 rtl/dsi_lane_gather.sv | 87 ++++++++
 rtl/dsi_lane_distributor.sv | 119 +++++++++++
 3 files changed

// File: rtl/dsi_lane_pkg.sv
// rtl/dsi_lane_pkg.sv - shared types and constants for the DSI lane distributor
package dsi_lane_pkg;

   localparam int         MAX_LANES = 8;
   localparam logic [7:0] PAD_BYTE  = 8'h00;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PREP  = 3'd1,
      DATA  = 3'd2,
      TRAIL = 3'd3,
      DONE  = 3'd4
   } lane_state_t;

endpackage

// File: rtl/dsi_lane_gather.sv
// rtl/dsi_lane_gather.sv - byte gather slots, slot index and beat output register
module dsi_lane_gather
   import dsi_lane_pkg::*;
#(
   parameter int NUM_LANES = 4,
   parameter int LCW       = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   clr,
   input  logic [LCW-1:0]         nl_m1,
   input  logic                   s_valid,
   input  logic [7:0]             s_data,
   input  logic                   s_last,
   output logic                   s_ready,
   input  logic                   ppi_tx_ready,
   output logic [NUM_LANES*8-1:0] ppi_data,
   output logic [NUM_LANES-1:0]   ppi_valid,
   output logic                   out_vld,
   output logic                   eop_taken
);

   logic [7:0]             slot [NUM_LANES];
   logic [LCW-1:0]         idx;
   logic                   accept;
   logic                   complete;
   logic [NUM_LANES*8-1:0] beat_data;
   logic [NUM_LANES-1:0]   beat_valid;

   // A new byte is only taken when the output register is free or draining this cycle,
   // so a completing byte can always load its beat on the same edge.
   assign s_ready  = en && !eop_taken && (!out_vld || ppi_tx_ready);
   assign accept   = s_valid && s_ready;
   assign complete = accept && (s_last || (idx == nl_m1));

   // Assemble the beat from the stored slots plus the byte arriving now; unused lanes are padded.
   always_comb begin
      beat_data  = '0;
      beat_valid = '0;
      for (int j = 0; j < NUM_LANES; j++) begin
         if (j < int'(idx)) begin
            beat_data[j*8 +: 8] = slot[j];
            beat_valid[j]       = 1'b1;
         end else if (j == int'(idx)) begin
            beat_data[j*8 +: 8] = s_data;
            beat_valid[j]       = 1'b1;
         end else begin
            beat_data[j*8 +: 8] = PAD_BYTE;
         end
      end
   end

   // Slot fill, beat load and beat drain; end-of-packet flag held until the FSM clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < NUM_LANES; j++) slot[j] <= PAD_BYTE;
         idx       <= '0;
         ppi_data  <= '0;
         ppi_valid <= '0;
         out_vld   <= 1'b0;
         eop_taken <= 1'b0;
      end else begin
         if (clr) begin
            eop_taken <= 1'b0;
         end else if (accept && s_last) begin
            eop_taken <= 1'b1;
         end
         if (complete) begin
            ppi_data  <= beat_data;
            ppi_valid <= beat_valid;
            out_vld   <= 1'b1;
            idx       <= '0;
         end else begin
            if (ppi_tx_ready) begin
               ppi_valid <= '0;
               out_vld   <= 1'b0;
            end
            if (accept) begin
               slot[idx] <= s_data;
               idx       <= idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/dsi_lane_distributor.sv
// rtl/dsi_lane_distributor.sv - stripes a DSI byte stream across active PPI HS lanes
module dsi_lane_distributor
   import dsi_lane_pkg::*;
#(
   parameter int NUM_LANES = 4,
   parameter int HS_PREP   = 3,
   parameter int HS_TRAIL  = 2,
   parameter int LCW       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                   dsi_clk,
   input  logic                   dsi_rst_n,
   input  logic [LCW-1:0]         lane_cfg,
   input  logic                   s_valid,
   input  logic [7:0]             s_data,
   input  logic                   s_last,
   output logic                   s_ready,
   input  logic                   ppi_tx_ready,
   output logic [NUM_LANES*8-1:0] ppi_data,
   output logic [NUM_LANES-1:0]   ppi_valid,
   output logic [NUM_LANES-1:0]   ppi_lane_en,
   output logic                   lane_done,
   output logic                   busy
);

   localparam int HS_MAX = (HS_PREP > HS_TRAIL) ? HS_PREP : HS_TRAIL;
   localparam int CW     = $clog2(HS_MAX + 1);

   lane_state_t          state;
   logic [CW-1:0]        cnt;
   logic [LCW-1:0]       nl_m1;
   logic [LCW-1:0]       cfg_m1;
   logic [NUM_LANES-1:0] cfg_mask;
   logic                 out_vld;
   logic                 eop_taken;

   // Clamp the requested lane count to the physical lanes and derive the enable mask.
   always_comb begin
      cfg_m1 = lane_cfg;
      if (int'(lane_cfg) >= NUM_LANES) cfg_m1 = LCW'(NUM_LANES - 1);
      cfg_mask = '0;
      for (int j = 0; j < NUM_LANES; j++) cfg_mask[j] = (j <= int'(cfg_m1));
   end

   assign busy = (state != IDLE);

   // Packet sequencing: HS prepare, data striping, HS trail and the done pulse.
   always_ff @(posedge dsi_clk or negedge dsi_rst_n) begin
      if (!dsi_rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         nl_m1       <= '0;
         ppi_lane_en <= '0;
         lane_done   <= 1'b0;
      end else begin
         lane_done <= 1'b0;
         case (state)
            IDLE: begin
               if (s_valid) begin
                  nl_m1       <= cfg_m1;
                  ppi_lane_en <= cfg_mask;
                  cnt         <= '0;
                  state       <= PREP;
               end
            end
            PREP: begin
               if (cnt == CW'(HS_PREP - 1)) begin
                  cnt   <= '0;
                  state <= DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (eop_taken && (!out_vld || ppi_tx_ready)) begin
                  cnt   <= '0;
                  state <= TRAIL;
               end
            end
            TRAIL: begin
               if (cnt == CW'(HS_TRAIL - 1)) begin
                  cnt         <= '0;
                  ppi_lane_en <= '0;
                  lane_done   <= 1'b1;
                  state       <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   dsi_lane_gather #(
      .NUM_LANES (NUM_LANES),
      .LCW       (LCW)
   ) u_gather (
      .clk          (dsi_clk),
      .rst_n        (dsi_rst_n),
      .en           (state == DATA),
      .clr          (state == DONE),
      .nl_m1        (nl_m1),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_last       (s_last),
      .s_ready      (s_ready),
      .ppi_tx_ready (ppi_tx_ready),
      .ppi_data     (ppi_data),
      .ppi_valid    (ppi_valid),
      .out_vld      (out_vld),
      .eop_taken    (eop_taken)
   );

endmodule
